// File: rtl/ycbcr422_rgb_ctrl_if.sv
// ---------------------------------------------------------------------------
// ycbcr422_rgb_ctrl_if
// Handshake between the packet receive FIFO (first-word-fall-through) and the
// display-side YCbCr 4:2:2 to RGB controller.
//
// Signals:
//   fifo_data  [28:27] x_count, [26:16] y_count, [15:8] Y, [7:0] C
//   fifo_empty FIFO has no word to offer
//   fifo_read  read strobe; the word on fifo_data is consumed this cycle
//
// Modports:
//   master  the controller (issues reads)
//   slave   the FIFO side (offers data)
// ---------------------------------------------------------------------------
interface ycbcr422_rgb_ctrl_if;
  logic [28:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_read;

  modport master (input fifo_data, input fifo_empty, output fifo_read);
  modport slave  (output fifo_data, output fifo_empty, input fifo_read);
endinterface

// File: rtl/ycbcr422_rgb_ctrl.sv
// ---------------------------------------------------------------------------
// ycbcr422_rgb_ctrl
// Drains packed YCbCr 4:2:2 pixels from the receive FIFO during the active
// window and converts them to clipped RGB in a fixed 3-stage pipeline.
// Adds tile selection, test patterns, FIFO-underflow protection and a
// per-line sequence check against the timing generator's line number.
//
// Ports:
//   i_clk_74M        pixel clock
//   i_rst            synchronous active-high reset
//   i_vcnt, i_hcnt   timing generator counters
//   i_mode           0 video, 1 gradient, 2 colour bars, 3 black
//   i_tile           tile index shown by this display
//   i_clr            clears underflow flag and both error counters
//   fifo             FIFO handshake (master side)
//   o_de             pixel valid, active window delayed by 3 cycles
//   o_r, o_g, o_b    RGB pixel
//   o_underflow      sticky underflow flag
//   o_line_err       one-cycle pulse on a line sequence mismatch
//   o_underflow_cnt  saturating underflow count
//   o_line_err_cnt   saturating line-error count
// ---------------------------------------------------------------------------
module ycbcr422_rgb_ctrl #(
  parameter logic [11:0] H_START   = 12'd1,
  parameter logic [11:0] H_FIN     = 12'd1201,
  parameter logic [11:0] V_START   = 12'd24,
  parameter logic [11:0] V_FIN     = 12'd745,
  parameter int          TILE_BITS = 2,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 i_clk_74M,
  input  logic                 i_rst,
  input  logic [11:0]          i_vcnt,
  input  logic [11:0]          i_hcnt,
  input  logic [1:0]           i_mode,
  input  logic [TILE_BITS-1:0] i_tile,
  input  logic                 i_clr,
  ycbcr422_rgb_ctrl_if.master  fifo,
  output logic                 o_de,
  output logic [7:0]           o_r,
  output logic [7:0]           o_g,
  output logic [7:0]           o_b,
  output logic                 o_underflow,
  output logic                 o_line_err,
  output logic [ERR_CNT_W-1:0] o_underflow_cnt,
  output logic [ERR_CNT_W-1:0] o_line_err_cnt
);

  // ---------------- active window ----------------
  logic hactive_reg, vactive_reg;
  logic active, fifo_read, slot_underflow;

  always_ff @(posedge i_clk_74M) begin
    if (i_rst) begin
      hactive_reg <= 1'b0;
      vactive_reg <= 1'b0;
    end else begin
      if (i_hcnt == H_START)    hactive_reg <= 1'b1;
      else if (i_hcnt == H_FIN) hactive_reg <= 1'b0;
      if (i_vcnt == V_START)    vactive_reg <= 1'b1;
      else if (i_vcnt == V_FIN) vactive_reg <= 1'b0;
    end
  end

  // Reads happen in every mode so the FIFO stream stays pixel-aligned even
  // while a test pattern is displayed.
  assign active         = hactive_reg & vactive_reg;
  assign fifo_read      = active & ~fifo.fifo_empty;
  assign slot_underflow = active & fifo.fifo_empty;
  assign fifo.fifo_read = fifo_read;

  // ---------------- line sequence check ----------------
  logic        line_pending_reg;
  logic [10:0] line_offset;
  logic        line_mismatch;

  assign line_offset   = 11'(i_vcnt - V_START);
  // Only the first successful read of a line is checked; an underflowed
  // slot leaves the check pending for the next real word.
  assign line_mismatch = fifo_read & line_pending_reg &
                         (fifo.fifo_data[26:16] != line_offset);

  always_ff @(posedge i_clk_74M) begin
    if (i_rst)                  line_pending_reg <= 1'b0;
    else if (i_hcnt == H_START) line_pending_reg <= 1'b1;
    else if (fifo_read)         line_pending_reg <= 1'b0;
  end

  // ---------------- error flag and counters ----------------
  logic [1:0] err_event;
  assign err_event = {line_mismatch, slot_underflow};

  always_ff @(posedge i_clk_74M) begin
    if (i_rst) begin
      o_underflow <= 1'b0;
      o_line_err  <= 1'b0;
    end else begin
      if (slot_underflow) o_underflow <= 1'b1;
      else if (i_clr)     o_underflow <= 1'b0;
      o_line_err <= line_mismatch;
    end
  end

  // A clear coinciding with a new event leaves the count at one.
  for (genvar gi = 0; gi < 2; gi++) begin : g_err_cnt
    logic [ERR_CNT_W-1:0] cnt_reg;
    always_ff @(posedge i_clk_74M) begin
      if (i_rst)
        cnt_reg <= '0;
      else if (err_event[gi])
        cnt_reg <= i_clr ? ERR_CNT_W'(1)
                 : ((&cnt_reg) ? cnt_reg : cnt_reg + ERR_CNT_W'(1));
      else if (i_clr)
        cnt_reg <= '0;
    end
  end

  assign o_underflow_cnt = g_err_cnt[0].cnt_reg;
  assign o_line_err_cnt  = g_err_cnt[1].cnt_reg;

  // ---------------- stage 1: latch ----------------
  logic                 s1_valid_reg, s1_uf_reg;
  logic [7:0]           s1_y_reg, cb_reg, cr_reg;
  logic [1:0]           s1_mode_reg;
  logic [TILE_BITS-1:0] s1_tile_reg, s1_xcount_reg;
  logic [7:0]           s1_hpat_reg, s1_vpat_reg;

  always_ff @(posedge i_clk_74M) begin
    if (i_rst) begin
      s1_valid_reg  <= 1'b0;
      s1_uf_reg     <= 1'b0;
      s1_y_reg      <= 8'd0;
      cb_reg        <= 8'd128;
      cr_reg        <= 8'd128;
      s1_mode_reg   <= 2'd0;
      s1_tile_reg   <= '0;
      s1_xcount_reg <= '0;
      s1_hpat_reg   <= 8'd0;
      s1_vpat_reg   <= 8'd0;
    end else begin
      s1_valid_reg <= active;
      s1_uf_reg    <= slot_underflow;
      s1_mode_reg  <= i_mode;
      s1_tile_reg  <= i_tile;
      s1_hpat_reg  <= i_hcnt[9:2];
      s1_vpat_reg  <= i_vcnt[8:1];
      if (fifo_read) begin
        s1_y_reg      <= fifo.fifo_data[15:8];
        s1_xcount_reg <= fifo.fifo_data[27 +: TILE_BITS];
      end
      // Neutral chroma at each line start so nothing bleeds across lines.
      if (i_hcnt == H_START) begin
        cb_reg <= 8'd128;
        cr_reg <= 8'd128;
      end else if (fifo_read) begin
        if (i_hcnt[0]) cb_reg <= fifo.fifo_data[7:0];
        else           cr_reg <= fifo.fifo_data[7:0];
      end
    end
  end

  // ---------------- stage 2: matrix terms ----------------
  logic signed [19:0] y20, cb20, cr20;
  logic signed [19:0] r_term_reg, g_term_reg, b_term_reg;
  logic               s2_valid_reg, s2_uf_reg, s2_tile_match_reg;
  logic [1:0]         s2_mode_reg;
  logic [7:0]         s2_hpat_reg, s2_vpat_reg;

  assign y20  = signed'({12'd0, s1_y_reg});
  assign cb20 = signed'({12'd0, cb_reg});
  assign cr20 = signed'({12'd0, cr_reg});

  always_ff @(posedge i_clk_74M) begin
    if (i_rst) begin
      r_term_reg        <= 20'sd0;
      g_term_reg        <= 20'sd0;
      b_term_reg        <= 20'sd0;
      s2_valid_reg      <= 1'b0;
      s2_uf_reg         <= 1'b0;
      s2_tile_match_reg <= 1'b0;
      s2_mode_reg       <= 2'd0;
      s2_hpat_reg       <= 8'd0;
      s2_vpat_reg       <= 8'd0;
    end else begin
      r_term_reg <= (y20 <<< 8) + (20'sd359 * cr20) - 20'sd45952;
      g_term_reg <= (y20 <<< 8) + 20'sd34688 - (20'sd183 * cr20) - (20'sd88 * cb20);
      b_term_reg <= (y20 <<< 8) + (20'sd454 * cb20) - 20'sd58112;
      s2_valid_reg      <= s1_valid_reg;
      s2_uf_reg         <= s1_uf_reg;
      s2_tile_match_reg <= (s1_xcount_reg == s1_tile_reg);
      s2_mode_reg       <= s1_mode_reg;
      s2_hpat_reg       <= s1_hpat_reg;
      s2_vpat_reg       <= s1_vpat_reg;
    end
  end

  // ---------------- stage 3: clip and select ----------------
  function automatic logic [7:0] clip8(input logic signed [19:0] term);
    logic signed [19:0] shifted;
    shifted = term >>> 8;
    if (shifted < 20'sd0)        clip8 = 8'd0;
    else if (shifted > 20'sd255) clip8 = 8'd255;
    else                         clip8 = shifted[7:0];
  endfunction

  logic [7:0] r_next, g_next, b_next;

  always_comb begin
    r_next = 8'd0;
    g_next = 8'd0;
    b_next = 8'd0;
    if (s2_valid_reg) begin
      case (s2_mode_reg)
        2'd1: begin
          g_next = s2_vpat_reg;
          b_next = s2_hpat_reg;
        end
        2'd2: begin
          // hpat holds hcnt[9:2], so hcnt[9:7] are its top three bits.
          r_next = {8{s2_hpat_reg[7]}};
          g_next = {8{s2_hpat_reg[6]}};
          b_next = {8{s2_hpat_reg[5]}};
        end
        2'd0: begin
          if (!s2_uf_reg && s2_tile_match_reg) begin
            r_next = clip8(r_term_reg);
            g_next = clip8(g_term_reg);
            b_next = clip8(b_term_reg);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk_74M) begin
    if (i_rst) begin
      o_de <= 1'b0;
      o_r  <= 8'd0;
      o_g  <= 8'd0;
      o_b  <= 8'd0;
    end else begin
      o_de <= s2_valid_reg;
      o_r  <= r_next;
      o_g  <= g_next;
      o_b  <= b_next;
    end
  end

endmodule
